branch_pred_ctrl: RTL and testbench

//  Branch prediction and redirect controller for the 5-stage pipeline.
//  IF stage: indexes a bimodal BHT (2-bit counters) and a direct-mapped BTB to predict next PC.
//  EX stage: consumes the branch comparator result, trains both tables, and detects mispredicts.
//  On a mispredict, issues a one-cycle registered redirect and flush to PC/IF/ID control.

---
 rtl/branch_pred_ctrl_pkg.sv | 15 +
 rtl/branch_pred_ctrl_sat_cnt2.sv | 20 ++
 rtl/branch_pred_ctrl.sv | 112 +++++++++++
 tb/tb_branch_pred_ctrl.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/branch_pred_ctrl_pkg.sv
// Shared encodings and default geometry for the branch prediction controller.
package branch_pred_ctrl_pkg;

  // Bimodal counter encodings: the MSB is the taken/not-taken prediction.
  typedef enum logic [1:0] {
    CNT_SNT = 2'b00,
    CNT_WNT = 2'b01,
    CNT_WT  = 2'b10,
    CNT_ST  = 2'b11
  } bht_cnt_e;

  localparam int IDX_W_DEF = 6;
  localparam int TAG_W_DEF = 8;

endpackage

// File: rtl/branch_pred_ctrl_sat_cnt2.sv
// Next-state of a 2-bit saturating up/down counter.
module branch_pred_ctrl_sat_cnt2
  import branch_pred_ctrl_pkg::*;
(
  input  logic [1:0] cnt,
  input  logic       up,
  output logic [1:0] cnt_next
);

  // Count toward strongly-taken on up, toward strongly-not-taken otherwise.
  always_comb begin
    cnt_next = cnt;
    if (up) begin
      if (cnt != CNT_ST) cnt_next = cnt + 2'd1;
    end else begin
      if (cnt != CNT_SNT) cnt_next = cnt - 2'd1;
    end
  end

endmodule

// File: rtl/branch_pred_ctrl.sv
// Bimodal BHT + direct-mapped BTB predictor with EX-stage training and a
// registered one-cycle redirect/flush pulse on mispredict.
module branch_pred_ctrl
  import branch_pred_ctrl_pkg::*;
#(
  parameter int          IDX_W    = IDX_W_DEF,
  parameter int          TAG_W    = TAG_W_DEF,
  parameter logic [1:0]  INIT_CNT = CNT_WNT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] IfPc,
  output logic        PredTaken,
  output logic [31:0] PredTarget,
  input  logic        Stall,
  input  logic        ExValid,
  input  logic [31:0] ExPc,
  input  logic [31:0] ExTarget,
  input  logic        ExBranchRes,
  input  logic        ExPredTaken,
  input  logic [31:0] ExPredTarget,
  output logic        Redirect,
  output logic [31:0] RedirectPc,
  output logic        Flush,
  output logic [31:0] BrCount,
  output logic [31:0] MissCount
);

  localparam int ENTRIES = 1 << IDX_W;

  logic [1:0]       bht        [ENTRIES];
  logic             btb_valid  [ENTRIES];
  logic [TAG_W-1:0] btb_tag    [ENTRIES];
  logic [31:0]      btb_target [ENTRIES];

  logic [IDX_W-1:0] if_idx, ex_idx;
  logic [TAG_W-1:0] if_tag, ex_tag;
  logic             resolve, target_miss, mispredict;
  logic [1:0]       cnt_next;
  logic [31:0]      redirect_pc_next;
  logic             unused_if_bits;

  assign if_idx = IfPc[IDX_W+1:2];
  assign if_tag = IfPc[IDX_W+TAG_W+1:IDX_W+2];
  assign ex_idx = ExPc[IDX_W+1:2];
  assign ex_tag = ExPc[IDX_W+TAG_W+1:IDX_W+2];

  // Only the index/tag fields of the fetch PC take part in the lookup.
  assign unused_if_bits = ^{IfPc[31:IDX_W+TAG_W+2], IfPc[1:0]};

  // Combinational lookup; a BTB miss or tag mismatch overrides the counter.
  always_comb begin
    PredTaken  = btb_valid[if_idx] && (btb_tag[if_idx] == if_tag) && bht[if_idx][1];
    PredTarget = btb_target[if_idx];
  end

  // The branch seen in EX during the redirect cycle is wrong-path and is dropped.
  assign resolve          = ExValid & ~Stall & ~Redirect;
  assign target_miss      = ExBranchRes & ExPredTaken & (ExPredTarget != ExTarget);
  assign mispredict       = resolve & ((ExBranchRes != ExPredTaken) | target_miss);
  assign redirect_pc_next = ExBranchRes ? ExTarget : (ExPc + 32'd4);

  branch_pred_ctrl_sat_cnt2 u_sat_cnt2 (
    .cnt      (bht[ex_idx]),
    .up       (ExBranchRes),
    .cnt_next (cnt_next)
  );

  // Train BHT on every resolve; fill BTB only on taken branches.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        bht[i]        <= INIT_CNT;
        btb_valid[i]  <= 1'b0;
        btb_tag[i]    <= '0;
        btb_target[i] <= '0;
      end
    end else if (resolve) begin
      bht[ex_idx] <= cnt_next;
      if (ExBranchRes) begin
        btb_valid[ex_idx]  <= 1'b1;
        btb_tag[ex_idx]    <= ex_tag;
        btb_target[ex_idx] <= ExTarget;
      end
    end
  end

  // Redirect pulse: set by a mispredict, self-clears the following cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Redirect   <= 1'b0;
      RedirectPc <= '0;
    end else begin
      Redirect <= mispredict;
      if (mispredict) RedirectPc <= redirect_pc_next;
    end
  end

  assign Flush = Redirect;

  // Saturating statistics counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      BrCount   <= '0;
      MissCount <= '0;
    end else begin
      if (resolve && (BrCount != 32'hFFFF_FFFF))      BrCount   <= BrCount + 32'd1;
      if (mispredict && (MissCount != 32'hFFFF_FFFF)) MissCount <= MissCount + 32'd1;
    end
  end

endmodule

// File: tb/tb_branch_pred_ctrl.sv
// Directed bench for branch_pred_ctrl with hand-computed expectations.
module tb_branch_pred_ctrl;

  logic        clk;
  logic        rst_n;
  logic [31:0] IfPc;
  logic        PredTaken;
  logic [31:0] PredTarget;
  logic        Stall;
  logic        ExValid;
  logic [31:0] ExPc;
  logic [31:0] ExTarget;
  logic        ExBranchRes;
  logic        ExPredTaken;
  logic [31:0] ExPredTarget;
  logic        Redirect;
  logic [31:0] RedirectPc;
  logic        Flush;
  logic [31:0] BrCount;
  logic [31:0] MissCount;

  int err_cnt = 0;
  int chk_cnt = 0;

  branch_pred_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .IfPc         (IfPc),
    .PredTaken    (PredTaken),
    .PredTarget   (PredTarget),
    .Stall        (Stall),
    .ExValid      (ExValid),
    .ExPc         (ExPc),
    .ExTarget     (ExTarget),
    .ExBranchRes  (ExBranchRes),
    .ExPredTaken  (ExPredTaken),
    .ExPredTarget (ExPredTarget),
    .Redirect     (Redirect),
    .RedirectPc   (RedirectPc),
    .Flush        (Flush),
    .BrCount      (BrCount),
    .MissCount    (MissCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one branch in EX for one cycle, then retire it.
  task automatic resolve(input logic [31:0] pc, input logic [31:0] tgt, input logic res,
                         input logic pt, input logic [31:0] ptgt);
    ExValid      = 1'b1;
    ExPc         = pc;
    ExTarget     = tgt;
    ExBranchRes  = res;
    ExPredTaken  = pt;
    ExPredTarget = ptgt;
    tick();
    ExValid = 1'b0;
  endtask

  // Expected prediction / redirect for the three not-taken resolves.
  logic [2:0] nt_pred = 3'b001;

  initial begin
    rst_n = 1'b0; IfPc = 32'h100; Stall = 1'b0; ExValid = 1'b0;
    ExPc = '0; ExTarget = '0; ExBranchRes = 1'b0; ExPredTaken = 1'b0; ExPredTarget = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    // 1. reset state
    chk("rst_pred", {31'd0, PredTaken}, 32'd0);
    chk("rst_redirect", {31'd0, Redirect}, 32'd0);
    chk("rst_flush", {31'd0, Flush}, 32'd0);
    chk("rst_brcnt", BrCount, 32'd0);
    chk("rst_misscnt", MissCount, 32'd0);
    chk("rst_rpc", RedirectPc, 32'd0);

    // 2. first taken branch, predicted not-taken
    resolve(32'h100, 32'h80, 1'b1, 1'b0, 32'h0);
    chk("t2_redirect", {31'd0, Redirect}, 32'd1);
    chk("t2_flush", {31'd0, Flush}, 32'd1);
    chk("t2_rpc", RedirectPc, 32'h80);
    chk("t2_miss", MissCount, 32'd1);
    chk("t2_br", BrCount, 32'd1);
    #1;
    chk("t2_pred", {31'd0, PredTaken}, 32'd1);
    chk("t2_ptgt", PredTarget, 32'h80);
    tick();
    chk("t2_redirect_off", {31'd0, Redirect}, 32'd0);
    chk("t2_flush_off", {31'd0, Flush}, 32'd0);

    // 3. three not-taken resolves: WT->WNT->SNT->SNT
    for (int i = 0; i < 3; i++) begin
      resolve(32'h100, 32'h80, 1'b0, nt_pred[i], 32'h80);
      chk("t3_redirect", {31'd0, Redirect}, {31'd0, nt_pred[i]});
      if (nt_pred[i]) chk("t3_rpc", RedirectPc, 32'h104);
      #1;
      chk("t3_pred", {31'd0, PredTaken}, 32'd0);
      tick();
    end
    chk("t3_br", BrCount, 32'd4);
    chk("t3_miss", MissCount, 32'd2);
    // Two taken updates from SNT: WNT (still 0) then WT (1); an underflow to ST would show 1 early.
    resolve(32'h100, 32'h80, 1'b1, 1'b0, 32'h0);
    chk("t3_uf_rpc", RedirectPc, 32'h80);
    #1;
    chk("t3_uf_pred_wnt", {31'd0, PredTaken}, 32'd0);
    tick();
    resolve(32'h100, 32'h80, 1'b1, 1'b0, 32'h0);
    #1;
    chk("t3_uf_pred_wt", {31'd0, PredTaken}, 32'd1);
    tick();
    chk("t3_br2", BrCount, 32'd6);
    chk("t3_miss2", MissCount, 32'd4);

    // 4. stall holds EX for three cycles
    IfPc = 32'h204; ExValid = 1'b1; Stall = 1'b1; ExPc = 32'h204; ExTarget = 32'h300;
    ExBranchRes = 1'b1; ExPredTaken = 1'b0; ExPredTarget = 32'h0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t4_stall_br", BrCount, 32'd6);
      chk("t4_stall_redirect", {31'd0, Redirect}, 32'd0);
    end
    chk("t4_stall_pred", {31'd0, PredTaken}, 32'd0);
    Stall = 1'b0;
    tick();
    ExValid = 1'b0;
    chk("t4_br", BrCount, 32'd7);
    chk("t4_miss", MissCount, 32'd5);
    chk("t4_redirect", {31'd0, Redirect}, 32'd1);
    chk("t4_rpc", RedirectPc, 32'h300);
    #1;
    chk("t4_pred", {31'd0, PredTaken}, 32'd1);
    tick();

    // 5. mispredict followed by a wrong-path branch during the redirect cycle
    resolve(32'h100, 32'h80, 1'b0, 1'b1, 32'h80);
    chk("t5_redirect", {31'd0, Redirect}, 32'd1);
    chk("t5_rpc", RedirectPc, 32'h104);
    resolve(32'h204, 32'h300, 1'b0, 1'b1, 32'h300);
    chk("t5_ign_redirect", {31'd0, Redirect}, 32'd0);
    chk("t5_ign_br", BrCount, 32'd8);
    chk("t5_ign_miss", MissCount, 32'd6);
    #1;
    chk("t5_ign_pred", {31'd0, PredTaken}, 32'd1);
    // back-to-back: correct branch in the cycle after the redirect
    resolve(32'h100, 32'h80, 1'b1, 1'b0, 32'h0);
    chk("t5_b2b_redirect1", {31'd0, Redirect}, 32'd1);
    tick();
    resolve(32'h204, 32'h300, 1'b1, 1'b1, 32'h300);
    chk("t5_b2b_redirect", {31'd0, Redirect}, 32'd0);
    chk("t5_b2b_br", BrCount, 32'd10);
    chk("t5_b2b_miss", MissCount, 32'd7);
    // aliasing: 0x200 shares BHT entry with 0x100 but misses on tag
    IfPc = 32'h100;
    #1;
    chk("t5_alias_hit", {31'd0, PredTaken}, 32'd1);
    IfPc = 32'h200;
    #1;
    chk("t5_alias_miss", {31'd0, PredTaken}, 32'd0);

    // 6. reset while a redirect is pending
    IfPc = 32'h204;
    resolve(32'h100, 32'h80, 1'b0, 1'b1, 32'h80);
    chk("t6_redirect", {31'd0, Redirect}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_redirect", {31'd0, Redirect}, 32'd0);
    chk("t6_rst_flush", {31'd0, Flush}, 32'd0);
    chk("t6_rst_br", BrCount, 32'd0);
    chk("t6_rst_miss", MissCount, 32'd0);
    chk("t6_rst_rpc", RedirectPc, 32'd0);
    chk("t6_rst_pred", {31'd0, PredTaken}, 32'd0);
    tick();
    rst_n = 1'b1;
    #1;
    // wraparound of PC+4
    resolve(32'h100, 32'h80, 1'b1, 1'b0, 32'h0);
    chk("t6_pre_rpc", RedirectPc, 32'h80);
    tick();
    resolve(32'hFFFF_FFFC, 32'h40, 1'b0, 1'b1, 32'h40);
    chk("t6_wrap_redirect", {31'd0, Redirect}, 32'd1);
    chk("t6_wrap_rpc", RedirectPc, 32'd0);
    chk("t6_wrap_br", BrCount, 32'd2);
    chk("t6_wrap_miss", MissCount, 32'd2);
    tick();

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
